// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
//   state_t    : write-port owner phase (zero-fill, then arbitrated run)
//   REG_*      : default register-file geometry
//   X0_ADDR    : hard-wired zero register, never written in RUN
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam int X0_ADDR    = 0;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// 2-way round-robin arbiter.
//   clk, rst   : clock, async active-high reset
//   valid[1:0] : request lines
//   accept     : the granted request was taken this cycle
//   grant[1:0] : one-hot grant (combinational), all-zero when idle
// rr_ptr names the requester that wins the next tie; it moves past the
// winner only on an accept, so a stalled grant keeps its priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Winner 0 hands priority to 1 and vice versa.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = grant[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= 1'b0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner.
// After reset it zero-fills every entry (when INIT_EN), then shares the
// single write port between the ALU (req0) and load (req1) writeback paths.
//   clk, rst                 : clock, async active-high reset
//   reqN_valid/ready         : writeback handshake, taken on valid&ready
//   reqN_addr/data           : destination rd and value
//   we3/addr3/wd3            : registered register-file write port
//   init_done                : zero-fill complete (sticky until reset)
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH    = REG_DATA_W,
  parameter bit INIT_EN       = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_data,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_data,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] addr3,
  output logic [DATA_WIDTH-1:0]    wd3,
  output logic                     init_done
);

  // One past the last entry; the extra counter bit flags fill completion.
  localparam logic [ADDRESS_WIDTH:0] FILL_END = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH-1:0] X0 = ADDRESS_WIDTH'(X0_ADDR);
  localparam state_t RST_STATE = INIT_EN ? INIT : RUN;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH:0]   cnt_q, cnt_d;
  logic                     we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0] addr3_q, addr3_d;
  logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;
  logic                     init_done_q, init_done_d;

  logic [1:0]               valid, grant, ready;
  logic                     run, accept;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;

  // rst gates ready directly so a RUN reset state cannot leak a handshake
  // while reset is still asserted.
  assign run    = (state_q == RUN) & ~rst;
  assign valid  = {req1_valid, req0_valid};
  assign ready  = grant & {2{run}};
  assign accept = |(valid & ready);

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  assign sel_addr = grant[1] ? req1_addr : req0_addr;
  assign sel_data = grant[1] ? req1_data : req0_data;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we3_d       = 1'b0;
    addr3_d     = addr3_q;
    wd3_d       = wd3_q;
    init_done_d = init_done_q;
    if (state_q == INIT) begin
      if (cnt_q == FILL_END) begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end else begin
        we3_d   = 1'b1;
        addr3_d = cnt_q[ADDRESS_WIDTH-1:0];
        wd3_d   = '0;
        cnt_d   = cnt_q + 1'b1;
      end
    end else begin
      init_done_d = 1'b1;
      // x0 still handshakes but is dropped; addr3/wd3 keep the last write.
      if (accept && sel_addr != X0) begin
        we3_d   = 1'b1;
        addr3_d = sel_addr;
        wd3_d   = sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      we3_q       <= 1'b0;
      addr3_q     <= '0;
      wd3_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we3_q       <= we3_d;
      addr3_q     <= addr3_d;
      wd3_q       <= wd3_d;
      init_done_q <= init_done_d;
    end
  end

  assign we3       = we3_q;
  assign addr3     = addr3_q;
  assign wd3       = wd3_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-cycle expected outputs are queued when
// stimulus is applied and compared one cycle later. A second instance with
// INIT_EN=0 covers the no-fill reset path.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, we3, init_done;
  logic [4:0]  addr3;
  logic [31:0] wd3;
  logic        ni_req0_ready, ni_req1_ready, ni_we3, ni_init_done;
  logic [4:0]  ni_addr3;
  logic [31:0] ni_wd3;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .INIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .we3(we3), .addr3(addr3), .wd3(wd3), .init_done(init_done)
  );

  regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .INIT_EN(1'b0)) dut_ni (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(ni_req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(ni_req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .we3(ni_we3), .addr3(ni_addr3), .wd3(ni_wd3), .init_done(ni_init_done)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   errs = 0, checks = 0;

  // reference model state
  bit          m_init, m_rr, m_done, m_acc0, m_acc1;
  int          m_cnt;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Called on a falling edge: retire last cycle's expectation, apply inputs,
  // check ready, queue the expectation for the coming edge.
  task automatic tick(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    exp_t e;
    bit   g0, g1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("we3", we3, e.we);
      if (e.we) begin
        chk("addr3", addr3, e.addr);
        chk("wd3", wd3, e.data);
      end
      chk("init_done", init_done, e.done);
    end
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    if (m_init) begin
      g0 = 1'b0; g1 = 1'b0;
    end else begin
      g0 = v0 & (!v1 | !m_rr);
      g1 = v1 & (!v0 | m_rr);
    end
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    m_acc0 = g0; m_acc1 = g1;
    e.we = 1'b0;
    if (m_init) begin
      if (m_cnt < 32) begin
        e.we = 1'b1; m_addr = 5'(m_cnt); m_data = '0; m_cnt++;
      end else begin
        m_init = 1'b0; m_done = 1'b1;
      end
    end else begin
      m_done = 1'b1;
      if (g0 || g1) begin
        m_rr = g0;
        if ((g0 ? a0 : a1) != 5'd0) begin
          e.we = 1'b1;
          m_addr = g0 ? a0 : a1;
          m_data = g0 ? d0 : d1;
        end
      end
    end
    e.addr = m_addr; e.data = m_data; e.done = m_done;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Assert rst between edges, check the asynchronous clear, release on a
  // falling edge one cycle later.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_we3", we3, 1'b0);
    chk("rst_addr3", addr3, 5'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_ni_ready", {ni_req1_ready, ni_req0_ready}, 2'b00);
    sb.delete();
    m_init = 1'b1; m_cnt = 0; m_rr = 1'b0; m_done = 1'b0;
    m_addr = '0; m_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic        r0v, r1v;
    logic [4:0]  r0a, r1a;
    logic [31:0] r0d, r1d;
    @(negedge clk);
    do_reset();
    // partial fill with both requesters pushing, then async reset at addr 17
    for (int i = 0; i < 18; i++) tick(1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
    chk("pre_rst_addr3", addr3, 5'd17);
    chk("pre_rst_we3", we3, 1'b1);
    sb.delete();
    do_reset();
    // full fill, then contention alternates 0,1,0,1...
    for (int i = 0; i < 33; i++) tick(1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
    for (int i = 0; i < 8; i++)  tick(1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
    tick(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    // single ALU write, then idle
    tick(1, 5'd10, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    tick(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    tick(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    // load to x0: handshake, no write, priority returns to 0
    tick(0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFFFFFF);
    tick(1, 5'd7, 32'h77, 1, 5'd8, 32'h88);
    tick(0, 5'd8, 32'h0, 1, 5'd8, 32'h88);
    // random traffic; a stalled requester holds its request
    r0v = 0; r1v = 0; r0a = '0; r1a = '0; r0d = '0; r1d = '0;
    m_acc0 = 1; m_acc1 = 1;
    for (int i = 0; i < 60; i++) begin
      if (!r0v || m_acc0) begin
        r0v = 1'($urandom_range(0, 1)); r0a = 5'($urandom); r0d = $urandom;
      end
      if (!r1v || m_acc1) begin
        r1v = 1'($urandom_range(0, 1)); r1a = 5'($urandom); r1d = $urandom;
      end
      tick(r0v, r0a, r0d, r1v, r1a, r1d);
    end
    tick(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    // INIT_EN=0 instance: accepts on the first cycle after release
    do_reset();
    req0_valid = 1; req0_addr = 5'd3; req0_data = 32'hABCD;
    req1_valid = 0;
    #1;
    chk("ni_first_ready", ni_req0_ready, 1'b1);
    tick(1, 5'd3, 32'hABCD, 0, 5'd0, 32'h0);
    chk("ni_we3", ni_we3, 1'b1);
    chk("ni_addr3", ni_addr3, 5'd3);
    chk("ni_wd3", ni_wd3, 32'hABCD);
    chk("ni_init_done", ni_init_done, 1'b1);
    tick(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("ni_idle_we3", ni_we3, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port (addr3/we3/wd3) of the 32-entry register file.
- After every reset, sequences a zero-fill of all registers; the storage array itself has no reset.
- Then shares the write port round-robin between two writeback requesters: 0 = ALU result path, 1 = load/data-memory path.
- Requesters use valid/ready handshakes; the outputs to the register file are registered.

Parameters:
- ADDRESS_WIDTH, 5, register index width; the block sequences 2**ADDRESS_WIDTH entries.
- DATA_WIDTH, 32, write data width.
- INIT_EN, 1, 1 = zero-fill after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset.
- req0_valid  in  1  ALU writeback request.
- req0_ready  out  1  ALU request accepted this cycle when valid&ready.
- req0_addr  in  ADDRESS_WIDTH  destination rd.
- req0_data  in  DATA_WIDTH  write data.
- req1_valid  in  1  load writeback request.
- req1_ready  out  1  load request accepted when valid&ready.
- req1_addr  in  ADDRESS_WIDTH  destination rd.
- req1_data  in  DATA_WIDTH  write data.
- we3  out  1  register-file write enable (registered).
- addr3  out  ADDRESS_WIDTH  register-file write address (registered).
- wd3  out  DATA_WIDTH  register-file write data (registered).
- init_done  out  1  high once zero-fill is complete (registered).

Interface rules:
- One clock, clk.
- rst is asynchronous and active-high.

Behaviour:
- Reset values while rst=1: we3=0, addr3=0, wd3=0, init_done=0, req0_ready=0, req1_ready=0, rr_ptr=0, init counter=0. State = INIT if INIT_EN=1, else RUN.
- INIT:
  - we3=1, wd3=0 for exactly 2**ADDRESS_WIDTH consecutive cycles.
  - addr3 steps 0,1,...,31, one per cycle; the first of these cycles is the first cycle after the first rising edge following rst release.
  - Both ready outputs are held 0; requests are ignored and not queued.
  - On the edge that retires addr3=31: state becomes RUN, init_done=1, we3=0.
- RUN, grant (combinational):
  - Only req0_valid → grant 0.
  - Only req1_valid → grant 1.
  - Both valid → grant rr_ptr.
  - Neither valid → no grant.
  - reqN_ready = (state==RUN) & grant==N, so at most one ready is high per cycle.
- RUN, accept on valid&ready:
  - Next cycle: we3=1, addr3=reqN_addr, wd3=reqN_data.
  - Latency is exactly 1 cycle; throughput is 1 write per cycle.
  - rr_ptr <= ~N after every accept, so contention strictly alternates.
- x0 rule: an accepted request with addr=0 completes its handshake normally, but we3 stays 0 that cycle. The block never writes x0 in RUN.
- No accept in a cycle → we3=0 next cycle; addr3/wd3 hold their previous values.
- A requester that is not granted must hold valid/addr/data stable. The arbiter keeps no request storage.
- rst asserted mid-INIT or mid-RUN: outputs go to reset values immediately. After release the zero-fill restarts from addr 0. An in-flight accepted write that has not yet reached the outputs is lost.
- init_done never falls except on rst.
- Widths: addresses and data pass through unmodified. The init counter is ADDRESS_WIDTH+1 bits so the terminal count is detectable without wrap.

Decomposition:
- Shared package (regfile_pkg):
  - typedef state_t {INIT, RUN}.
  - localparams REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - localparam X0_ADDR=0.
- Sub-module rr_arb2: 2-way round-robin arbiter holding rr_ptr (inputs valid[1:0], accept; output grant/one-hot). It is natural to split out for reuse by a future memory-port arbiter.
- All other logic (FSM, init counter, output registers) stays in the top.

Test Plan:
- Reset release with INIT_EN=1, both valid held high → we3=1 for 32 cycles, addr3=0..31, wd3=0; ready=0 throughout; init_done=1 and req0_ready=1 (rr_ptr=0) in the cycle after addr3=31.
- RUN, only req0 valid, addr=10, data=0xDEADBEEF → req0_ready=1 the same cycle; next cycle we3=1, addr3=10, wd3=0xDEADBEEF; the following cycle we3=0.
- RUN, both valid continuously (req0 addr 5 data 0x11, req1 addr 6 data 0x22) → accepts alternate 0,1,0,1; addr3 sequence 5,6,5,6; never both ready.
- RUN, req1 valid, addr=0, data=0xFFFFFFFF → req1_ready=1; the next cycle we3=0; rr_ptr becomes 0.
- rst pulsed asynchronously (between edges) at init step addr3=17 → we3/addr3/init_done clear without waiting for an edge; after release the fill restarts at addr3=0 and runs 32 full cycles.
- INIT_EN=0, req0 valid on the first cycle after reset release → immediate accept, init_done=1, no zero-fill writes observed.
